uart_tx_feeder: RTL and testbench

Byte-buffering stage placed directly upstream of the UART transmitter in `uart_top`. It accepts bytes from a producer at full `clk` rate into a FIFO, then presents them one at a time on the transmitter's `newd`/`dintx` inputs. It holds each request until the transmitter reports frame completion on `donetx`, which bridges the fast producer to the slow `uclk`-paced serial link. A watchdog discards a byte if the transmitter never completes its frame.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_byte_fifo.sv | 79 +++++++
 rtl/uart_tx_feeder.sv | 122 ++++++++++++
 tb/tb_uart_tx_feeder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } feeder_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with a pop port; occupancy drives full/empty and a
// registered overflow pulse flags dropped writes.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = UART_BYTE_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          overflow_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign rd_data_o  = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pop        = pop_i && !empty_o;
    // A pop on a full FIFO frees the slot this same cycle, so the write lands.
    push       = wr_en_i && (!full_o || pop);
    overflow_d = wr_en_i && full_o && !pop;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is deliberately left out of reset; pointers and count
  // define which entries are valid, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and presents them one at a time to the UART
// transmitter, holding each request until donetx rises or the watchdog expires.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int CW            = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [CW-1:0]          count,
  output logic                   overflow,
  output logic                   newd,
  output logic [UART_BYTE_W-1:0] dintx,
  input  logic                   donetx,
  output logic                   busy,
  output logic                   sent,
  output logic                   timeout_err
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  feeder_state_t          state_q, state_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   newd_q, newd_d;
  logic [UART_BYTE_W-1:0] dintx_q, dintx_d;
  logic                   sent_q, sent_d;
  logic                   tmo_q, tmo_d;
  logic                   donetx_q;
  logic                   done_rise;
  logic                   pop;
  logic [UART_BYTE_W-1:0] fifo_head;

  uart_byte_fifo #(
    .DEPTH (DEPTH),
    .W     (UART_BYTE_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .pop_i      (pop),
    .rd_data_o  (fifo_head),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty),
    .overflow_o (overflow)
  );

  // donetx comes from a clk-derived uclk register, so one flop is enough.
  assign done_rise = donetx && !donetx_q;

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    newd_d  = newd_q;
    dintx_d = dintx_q;
    sent_d  = 1'b0;
    tmo_d   = 1'b0;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          dintx_d = fifo_head;
          newd_d  = 1'b1;
          wd_d    = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // A completion arriving on the last watchdog cycle still counts as sent.
        if (done_rise) begin
          newd_d  = 1'b0;
          sent_d  = 1'b1;
          state_d = IDLE;
        end else if (wd_q == WD_LAST) begin
          newd_d  = 1'b0;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wd_q     <= '0;
      newd_q   <= 1'b0;
      dintx_q  <= '0;
      sent_q   <= 1'b0;
      tmo_q    <= 1'b0;
      donetx_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wd_q     <= wd_d;
      newd_q   <= newd_d;
      dintx_q  <= dintx_d;
      sent_q   <= sent_d;
      tmo_q    <= tmo_d;
      donetx_q <= donetx;
    end
  end

  assign newd        = newd_q;
  assign dintx       = dintx_q;
  assign sent        = sent_q;
  assign timeout_err = tmo_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a queue-based reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int TMO   = 64;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          donetx;

  logic          full, empty, overflow, newd, busy, sent, timeout_err;
  logic [CW-1:0] count;
  logic [7:0]    dintx;

  logic          l_full, l_empty, l_overflow, l_newd, l_busy, l_sent, l_timeout_err;
  logic [CW-1:0] l_count;
  logic [7:0]    l_dintx;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .newd(newd), .dintx(dintx), .donetx(donetx), .busy(busy),
    .sent(sent), .timeout_err(timeout_err)
  );

  // Default watchdog instance, used for the long 1200-cycle frame.
  uart_tx_feeder #(.DEPTH(DEPTH)) dut_long (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(l_full), .empty(l_empty), .count(l_count), .overflow(l_overflow),
    .newd(l_newd), .dintx(l_dintx), .donetx(donetx), .busy(l_busy),
    .sent(l_sent), .timeout_err(l_timeout_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;
  logic [7:0] got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Inputs as seen by the DUT at the most recent rising edge.
  logic s_rst = 1'b1, s_wr_en = 1'b0, s_donetx = 1'b0;
  logic [7:0] s_wr_data = 8'h00;
  always @(posedge clk) begin
    s_rst     <= rst;
    s_wr_en   <= wr_en;
    s_wr_data <= wr_data;
    s_donetx  <= donetx;
  end

  // Reference model: a byte queue, the byte on offer, and how long it has waited.
  logic [7:0] m_q[$];
  logic       m_newd = 1'b0, m_sent = 1'b0, m_tmo = 1'b0, m_ovf = 1'b0, m_prev = 1'b0;
  logic [7:0] m_dintx = 8'h00;
  int         m_age = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (s_rst) begin
        m_q.delete();
        m_newd = 1'b0; m_dintx = 8'h00; m_age = 0;
        m_sent = 1'b0; m_tmo = 1'b0; m_ovf = 1'b0; m_prev = 1'b0;
      end else begin
        automatic logic rise     = s_donetx && !m_prev;
        automatic logic take     = !m_newd && (m_q.size() > 0);
        automatic logic was_full = (m_q.size() == DEPTH);
        m_ovf  = s_wr_en && was_full && !take;
        m_sent = m_newd && rise;
        m_tmo  = m_newd && !rise && (m_age >= TMO - 1);
        if (take) begin
          m_dintx = m_q.pop_front();
          m_newd  = 1'b1;
          m_age   = 0;
        end else if (m_sent || m_tmo) begin
          m_newd = 1'b0;
        end else if (m_newd && m_age < TMO - 1) begin
          m_age++;
        end
        if (s_wr_en && (!was_full || take)) m_q.push_back(s_wr_data);
        m_prev = s_donetx;
      end
      if (cmp_en) begin
        check("m_newd",     newd,        m_newd);
        check("m_dintx",    dintx,       m_dintx);
        check("m_count",    count,       m_q.size());
        check("m_full",     full,        m_q.size() == DEPTH);
        check("m_empty",    empty,       m_q.size() == 0);
        check("m_busy",     busy,        m_newd);
        check("m_sent",     sent,        m_sent);
        check("m_overflow", overflow,    m_ovf);
        check("m_timeout",  timeout_err, m_tmo);
      end
    end
  end

  // Transmitter stand-in: wait for a request, record it, complete it after gap cycles.
  task automatic serve(input int n, input int gap);
    for (int f = 0; f < n; f++) begin
      int w = 0;
      while (newd !== 1'b1 && w < 200) begin
        tick(1);
        w++;
      end
      check("serve_newd_seen", newd, 1);
      got.push_back(dintx);
      tick(gap);
      donetx = 1'b1;
      tick(1);
      donetx = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL global_time_limit @%0t: actual=running required=finished", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; donetx = 1'b0;
    tick(3);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_newd", newd, 0);
    check("rst_dintx", dintx, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_flags", {sent, overflow, timeout_err}, 3'b000);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Single byte, completion 1200 cycles later on the default-watchdog instance.
    wr_en = 1'b1; wr_data = 8'hA5;
    tick(1); wr_en = 1'b0;
    check("t1_count_after_write", count, 1);
    check("t1_newd_not_yet", newd, 0);
    tick(1);
    check("t1_newd", newd, 1);
    check("t1_dintx", dintx, 8'hA5);
    check("t1_long_newd", l_newd, 1);
    check("t1_long_dintx", l_dintx, 8'hA5);
    tick(1198);
    check("t1_long_still_waiting", l_newd, 1);
    donetx = 1'b1;
    tick(1);
    check("t1_long_sent", l_sent, 1);
    check("t1_long_newd_drop", l_newd, 0);
    check("t1_long_count", l_count, 0);
    check("t1_long_no_timeout", l_timeout_err, 0);
    check("t1_idle_rise_ignored", sent, 0);
    donetx = 1'b0;
    tick(2);
    check("t1_long_sent_once", l_sent, 0);

    // Fill to DEPTH behind a held frame, then one write too many.
    wr_en = 1'b1; wr_data = 8'hC3;
    tick(1);
    for (int i = 1; i <= 16; i++) begin
      wr_data = 8'(i);
      tick(1);
    end
    check("t2_full", full, 1);
    check("t2_count16", count, 16);
    wr_data = 8'hFF;
    tick(1); wr_en = 1'b0;
    check("t2_overflow", overflow, 1);
    check("t2_count_kept", count, 16);
    tick(1);
    check("t2_overflow_pulse", overflow, 0);
    got.delete();
    serve(17, 5);
    check("t2_n_delivered", got.size(), 17);
    check("t2_primer", got[0], 8'hC3);
    for (int i = 1; i < 17 && i < got.size(); i++) check("t2_order", got[i], i);
    tick(3);
    check("t2_drained", empty, 1);

    // Full FIFO, then write during the IDLE pop cycle.
    wr_en = 1'b1; wr_data = 8'h3C;
    tick(1);
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'h20 + 8'(i);
      tick(1);
    end
    wr_en = 1'b0;
    check("t3_full", full, 1);
    donetx = 1'b1;
    tick(1);
    donetx = 1'b0;
    check("t3_sent", sent, 1);
    check("t3_newd_gap", newd, 0);
    check("t3_count_pre", count, 16);
    wr_en = 1'b1; wr_data = 8'hEE;
    tick(1); wr_en = 1'b0;
    check("t3_count_kept", count, 16);
    check("t3_no_overflow", overflow, 0);
    check("t3_next_newd", newd, 1);
    check("t3_next_dintx", dintx, 8'h20);
    got.delete();
    serve(17, 3);
    check("t3_n_delivered", got.size(), 17);
    if (got.size() == 17) begin
      check("t3_first", got[0], 8'h20);
      check("t3_mid", got[15], 8'h2F);
      check("t3_last", got[16], 8'hEE);
    end
    tick(3);

    // Watchdog expiry with a second byte queued behind.
    wr_en = 1'b1; wr_data = 8'h55;
    tick(1); wr_data = 8'h66;
    tick(1); wr_en = 1'b0;
    check("t4_newd", newd, 1);
    check("t4_dintx", dintx, 8'h55);
    tick(63);
    check("t4_pre_timeout", {newd, timeout_err}, 2'b10);
    tick(1);
    check("t4_timeout", timeout_err, 1);
    check("t4_newd_drop", newd, 0);
    check("t4_no_sent", sent, 0);
    tick(1);
    check("t4_next_newd", newd, 1);
    check("t4_next_dintx", dintx, 8'h66);
    check("t4_timeout_pulse", timeout_err, 0);
    tick(64);
    check("t4_second_timeout", timeout_err, 1);
    tick(3);

    // Completion on the final watchdog cycle wins over the timeout.
    wr_en = 1'b1; wr_data = 8'h77;
    tick(1); wr_en = 1'b0;
    tick(1);
    check("t5_newd", newd, 1);
    check("t5_dintx", dintx, 8'h77);
    tick(63);
    donetx = 1'b1;
    tick(1);
    donetx = 1'b0;
    check("t5_sent", sent, 1);
    check("t5_no_timeout", timeout_err, 0);
    check("t5_newd_drop", newd, 0);
    tick(2);

    // Reset mid-frame with five bytes queued; a later donetx rise is stale.
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'h90 + 8'(i);
      tick(1);
    end
    wr_en = 1'b0;
    check("t6_count5", count, 5);
    check("t6_newd", newd, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_rst_newd", newd, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_busy", busy, 0);
    tick(2);
    donetx = 1'b1;
    tick(1);
    donetx = 1'b0;
    check("t6_stale_no_sent", sent, 0);
    check("t6_stays_idle", newd, 0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
